// File: rtl/frame_stream_reader_pkg.sv
// Shared types and constants for the frame stream reader: FSM states,
// default frame geometry and the BRAM address width helper.
package frame_stream_pkg;

    localparam int DEFAULT_WIDTH  = 320;
    localparam int DEFAULT_HEIGHT = 240;
    localparam int FRAME_PIXELS   = DEFAULT_WIDTH * DEFAULT_HEIGHT;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    // A one-pixel frame still needs a one-bit address bus.
    function automatic int addr_width(input int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

// File: rtl/frame_stream_reader_if.sv
// Valid/ready pixel stream used between the stages of the VGA image path.
interface dstream #(
    parameter int W = 12
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/frame_stream_reader_stream_fifo2.sv
// Two-entry first-word-fall-through FIFO; slot0 is always the head entry.
module stream_fifo2 #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   level;
    logic         do_pop;

    assign do_pop = pop && (level != 2'd0);
    assign head   = slot0;
    assign count  = level;

    // A pop with a simultaneous push keeps the level; the new word lands behind any survivor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0 <= '0;
            slot1 <= '0;
            level <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (level == 2'd0) begin
                        slot0 <= push_data;
                        level <= 2'd1;
                    end else if (level == 2'd1) begin
                        slot1 <= push_data;
                        level <= 2'd2;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    level <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_stream_reader.sv
// Reads one raster-order frame from a 1-cycle-latency BRAM per start request
// and streams it out with valid/ready flow control.
module frame_stream_reader
    import frame_stream_pkg::*;
#(
    parameter int  W            = 12,
    parameter int  image_width  = DEFAULT_WIDTH,
    parameter int  image_height = DEFAULT_HEIGHT,
    localparam int PIXELS       = image_width * image_height,
    localparam int ADDR_W       = addr_width(PIXELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [W-1:0]      bram_rdata,
    dstream.master            y
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t       state;
    state_t       state_next;
    logic         inflight;
    logic         pop;
    logic [1:0]   fifo_count;
    logic [W-1:0] fifo_head;
    logic [2:0]   pending;

    stream_fifo2 #(.W(W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bram_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign y.valid = (fifo_count != 2'd0);
    assign y.data  = fifo_head;
    assign pop     = y.valid && y.ready;
    assign busy    = (state != IDLE);

    // Words the buffer must still hold after this edge; reads are only issued while a slot is free.
    assign pending = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_next = state;
        bram_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = STREAM;
            end
            STREAM: begin
                bram_en = (pending < 3'd2);
                if (bram_en && (bram_addr == LAST_ADDR)) state_next = DRAIN;
            end
            DRAIN: begin
                if (pending == 3'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bram_addr <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= bram_en;
            done     <= (state == DRAIN) && (state_next == IDLE);
            if ((state == IDLE) && (state_next == STREAM)) begin
                bram_addr <= '0;
            end else if (bram_en) begin
                bram_addr <= bram_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_reader.sv
// Self-checking bench for frame_stream_reader on a 4x3 frame with mem[a] = a + 16.
module tb_frame_stream_reader;

    localparam int W    = 12;
    localparam int IW   = 4;
    localparam int IH   = 3;
    localparam int NPIX = IW * IH;
    localparam int AW   = 4;

    typedef struct {
        logic         start;
        logic         ready;
        logic         valid;
        logic [W-1:0] data;
        logic         busy;
        logic         done;
        logic         en;
    } vec_t;

    logic          clk = 1'b0;
    logic          clk_run = 1'b1;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [W-1:0]  bram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    dstream #(.W(W)) y_if ();

    frame_stream_reader #(
        .W            (W),
        .image_width  (IW),
        .image_height (IH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_rdata (bram_rdata),
        .y          (y_if)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(posedge clk) begin
        if (bram_en) bram_rdata <= W'(bram_addr) + W'(16);
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: pixel k of every frame is k+16, reads go out in address order,
    // never more than two words owed, and done follows the last handshake by one cycle.
    int           hs_total = 0;
    int           en_total = 0;
    int           done_total = 0;
    int           exp_idx = 0;
    int           issue_idx = 0;
    int           outstanding = 0;
    logic         last_hs_prev = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         mon_hs;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            exp_idx      = 0;
            issue_idx    = 0;
            outstanding  = 0;
            last_hs_prev = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            mon_hs = y_if.valid && y_if.ready;
            if (prev_stall) begin
                check("hold_valid", int'(y_if.valid), 1);
                check("hold_data", int'(y_if.data), int'(prev_data));
            end
            if (done || last_hs_prev) begin
                check("done_pulse", int'(done), int'(last_hs_prev));
                if (done) check("busy_at_done", int'(busy), 0);
            end
            if (done) done_total++;
            if (bram_en) begin
                check("bram_addr", int'(bram_addr), issue_idx);
                check("no_overissue", int'((outstanding - int'(mon_hs)) <= 1), 1);
                issue_idx = (issue_idx + 1) % NPIX;
                en_total++;
            end
            last_hs_prev = 1'b0;
            if (mon_hs) begin
                check("pixel_data", int'(y_if.data), 16 + exp_idx);
                exp_idx++;
                hs_total++;
                if (exp_idx == NPIX) begin
                    exp_idx      = 0;
                    last_hs_prev = 1'b1;
                end
            end
            outstanding = outstanding + int'(bram_en) - int'(mon_hs);
            prev_stall  = y_if.valid && !y_if.ready;
            prev_data   = y_if.data;
        end
    end

    task automatic apply_stimulus(input logic s, input logic r);
        @(posedge clk);
        #1;
        start      = s;
        y_if.ready = r;
    endtask

    task automatic check_output(input int c, input vec_t v);
        check($sformatf("vec%0d_valid", c), int'(y_if.valid), int'(v.valid));
        check($sformatf("vec%0d_busy", c), int'(busy), int'(v.busy));
        check($sformatf("vec%0d_done", c), int'(done), int'(v.done));
        check($sformatf("vec%0d_en", c), int'(bram_en), int'(v.en));
        if (v.valid) check($sformatf("vec%0d_data", c), int'(y_if.data), int'(v.data));
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic wait_hs(input int value, input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (y_if.valid && y_if.ready && (int'(y_if.data) == value)) begin
                seen = 1;
                break;
            end
        end
        check($sformatf("hs_%0d_seen", value), int'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[16];
        int   d0, h0, e0, frames, cycles;
        logic restart_pending;

        for (int c = 0; c < 16; c++) begin
            vecs[c].start = (c == 0);
            vecs[c].ready = 1'b1;
            vecs[c].valid = (c >= 3) && (c <= 14);
            vecs[c].data  = vecs[c].valid ? W'(16 + c - 3) : '0;
            vecs[c].busy  = (c >= 1) && (c <= 14);
            vecs[c].done  = (c == 15);
            vecs[c].en    = (c >= 1) && (c <= 12);
        end

        y_if.ready = 1'b1;
        #12;
        $display("[TB] reset state");
        check("rst_valid", int'(y_if.valid), 0);
        check("rst_data", int'(y_if.data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_en", int'(bram_en), 0);
        check("rst_addr", int'(bram_addr), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] full frame, ready held high");
        for (int c = 0; c < 16; c++) begin
            apply_stimulus(vecs[c].start, vecs[c].ready);
            @(negedge clk);
            check_output(c, vecs[c]);
        end
        apply_stimulus(1'b0, 1'b1);

        $display("[TB] async reset with clock stopped");
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clk_run = 1'b0;
        check("pre_rst_valid", int'(y_if.valid), 1);
        #2 reset = 1'b0;
        #1;
        check("async_valid", int'(y_if.valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_en", int'(bram_en), 0);
        check("async_done", int'(done), 0);
        check("async_data", int'(y_if.data), 0);
        #10 clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] backpressure");
        d0 = done_total;
        h0 = hs_total;
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        wait_hs(20, 40);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b0);
            @(negedge clk);
            check("stall_valid", int'(y_if.valid), 1);
            check("stall_data", int'(y_if.data), 21);
            check("stall_en", int'(bram_en), 0);
        end
        apply_stimulus(1'b0, 1'b1);
        wait_done(40);
        #1;
        check("bp_handshakes", hs_total - h0, NPIX);
        check("bp_done_count", done_total - d0, 1);

        $display("[TB] random ready, three back-to-back frames");
        d0 = done_total;
        h0 = hs_total;
        e0 = en_total;
        frames = 0;
        cycles = 0;
        restart_pending = 1'b0;
        apply_stimulus(1'b1, 1'($urandom % 2));
        while ((frames < 3) && (cycles < 2000)) begin
            @(posedge clk);
            #1;
            if (restart_pending) begin
                check("no_gap_busy", int'(busy), 1);
                restart_pending = 1'b0;
            end
            y_if.ready = 1'($urandom % 2);
            if (done) begin
                frames++;
                start = (frames < 3);
                restart_pending = (frames < 3);
            end else begin
                start = 1'b0;
            end
            cycles++;
        end
        check("rand_frames", frames, 3);
        @(negedge clk);
        #1;
        start      = 1'b0;
        y_if.ready = 1'b1;
        check("rand_handshakes", hs_total - h0, 3 * NPIX);
        check("rand_reads", en_total - e0, 3 * NPIX);
        check("rand_done_count", done_total - d0, 3);

        $display("[TB] start while busy");
        d0 = done_total;
        h0 = hs_total;
        e0 = en_total;
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        wait_hs(21, 40);
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        wait_done(40);
        #1;
        check("busy_start_hs", hs_total - h0, NPIX);
        check("busy_start_reads", en_total - e0, NPIX);
        check("busy_start_done", done_total - d0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_after", int'(busy), 0);
        end

        $display("[TB] reset mid-frame");
        d0 = done_total;
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        wait_hs(22, 40);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("abort_valid", int'(y_if.valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_abort", int'(done), 0);
        end
        h0 = hs_total;
        apply_stimulus(1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1);
        wait_hs(16, 10);
        wait_done(40);
        #1;
        check("restart_hs", hs_total - h0, NPIX);
        check("restart_done", done_total - d0, 1);

        apply_stimulus(1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
Streaming pixel source for the VGA image path. On a start pulse it reads one frame of image_width x image_height pixels from a 1-cycle-latency BRAM frame buffer in raster order and drives them onto a dstream output with valid/ready flow control. It is the producer that feeds the convolution stage's dstream input. It never drops or duplicates pixels under backpressure.

Parameters:
W, 12, pixel width in bits (matches the downstream stream data width)
image_width, 320, pixels per line
image_height, 240, lines per frame
ADDR_W, $clog2(image_width*image_height), BRAM address width (derived, not overridden)

Ports:
clk  input  1  system clock; all state is rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  frame request; sampled only in IDLE
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse after the last pixel handshakes
bram_addr  output  ADDR_W  frame buffer read address
bram_en  output  1  read enable; a read is issued when high
bram_rdata  input  W  read data, valid exactly one cycle after bram_en
y  dstream.out  W  pixel stream: y.data, y.valid, y.ready (input)

Behaviour:
- Reset (reset low, no clock needed): state=IDLE; bram_addr=0, bram_en=0, busy=0, done=0, y.valid=0, y.data=0; buffer emptied; in-flight flag cleared.
- Output buffer: 2-entry FIFO; y.valid = buffer non-empty; y.data = head entry. Pop on y.valid & y.ready.
- y.data and y.valid are held stable while y.valid & !y.ready.
- In-flight flag: set the cycle after bram_en=1. When set, bram_rdata is pushed into the buffer on that edge.
- Issue rule: bram_en = (state==STREAM) & (occupancy + inflight - pop < 2). pop is the same-cycle handshake. This sustains 1 pixel/clk when y.ready is held high and can never overflow the buffer.
- bram_addr increments by 1 after each issued read. It wraps to 0 on entering STREAM.
- FSM:
  IDLE -> STREAM when start=1; addr is cleared.
  STREAM -> DRAIN on the edge that issues address image_width*image_height-1.
  DRAIN -> IDLE when buffer is empty, no read is in flight, and no pop is pending; done=1 in the first IDLE cycle only.
- Latency: if start is sampled at edge E0, bram_en=1 with addr 0 follows E0, and y.valid first rises after E2 (3 edges).
- start while busy: ignored, with no effect on the frame in progress.
- start in the cycle where done=1: accepted; the next frame begins without a gap cycle.
- Simultaneous push and pop: occupancy unchanged; FIFO order preserved.
- Exactly image_width*image_height handshakes per frame; pixel k carries mem[k].
- Reset mid-frame: frame abandoned immediately; no done pulse; buffered pixels discarded.

Decomposition:
- Package frame_stream_pkg: FRAME_PIXELS = image_width*image_height; the state enum {IDLE, STREAM, DRAIN}; helper function for address width.
- Sub-module stream_fifo2: a 2-entry FIFO with push/pop/occupancy, using the same async active-low reset. It is reusable for other stream stages.
- The BRAM itself is outside this block; benches provide a behavioural 1-cycle-latency model.

Test Plan:
(Use image_width=4, image_height=3, BRAM model mem[a]=a+16.)
1. Reset: drive reset low mid-cycle with clk stopped -> y.valid=0, busy=0, bram_en=0 and done=0 immediately.
2. Full frame with y.ready=1: start pulse -> y.valid rises 3 edges after start; 12 consecutive handshakes carry data 16..27; done high for 1 cycle the cycle after the final pop; busy low with it.
3. Backpressure: hold y.ready=0 for 5 cycles after pixel 5 handshakes -> y.data=21 held stable; bram_en stops after 2 entries are buffered or in flight; the resumed stream gives 21..27 with no loss or duplicate.
4. Random y.ready (50%) over 3 back-to-back frames, each started on its done cycle -> 36 handshakes in order with no idle cycles between frames; bram_en count equals 36.
5. start pulsed at pixel 6 while busy -> ignored; the frame completes normally with a single done.
6. reset low at pixel 7, then released and start -> the new frame begins at data 16; no done for the aborted frame.
